// File: rtl/fpu_addsub_core.sv
// Multi-cycle IEEE-754 single-precision add/subtract core with iterative shifters.
// Optional build macro FPU_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise round-toward-zero.
module fpu_addsub_core #(
  parameter int unsigned ALIGN_LIMIT = 26
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  localparam int unsigned EW = 9;   // working exponent, one spare bit for overflow
  localparam int unsigned MW = 27;  // hidden + 23 fraction + G/R/S
  localparam int unsigned SW = 28;  // MW plus carry

  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [4:0]  FLG_INV   = 5'b10000;
  localparam logic [4:0]  FLG_OVF   = 5'b01000;
  localparam logic [4:0]  FLG_UNF   = 5'b00100;
  localparam logic [4:0]  FLG_INX   = 5'b00010;
  localparam logic [4:0]  FLG_ZERO  = 5'b00001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   result_q, result_d;
  logic [4:0]    flags_q, flags_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic          sx_q, sx_d;
  logic          sy_q, sy_d;
  logic [EW-1:0] ex_q, ex_d;
  logic [SW-1:0] mx_q, mx_d;
  logic [MW-1:0] my_q, my_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [31:0]   pres_q, pres_d;
  logic [4:0]    pflg_q, pflg_d;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

  // Operand classification of the latched inputs
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge_b;

  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign fa     = a_q[22:0];
  assign fb     = b_q[22:0];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_ge_b = (a_q[30:0] >= b_q[30:0]);

  // Mantissa add/subtract and rounding datapath
  logic [SW-1:0] mag_sum, mag_diff;
  logic [23:0]   rnd_mant;
  logic          rnd_inc, rnd_inexact;
  logic [24:0]   rnd_sum;
  logic [22:0]   rnd_frac;
  logic [EW-1:0] rnd_exp;

  assign mag_sum  = {1'b0, mx_q[MW-1:0]} + {1'b0, my_q};
  assign mag_diff = {1'b0, mx_q[MW-1:0]} - {1'b0, my_q};

  always_comb begin
    rnd_mant    = mx_q[26:3];
    rnd_inexact = |mx_q[2:0];
`ifdef FPU_ROUND_NEAREST_EN
    rnd_inc     = mx_q[2] & (mx_q[1] | mx_q[0] | mx_q[3]);
`else
    rnd_inc     = 1'b0;
`endif
    rnd_sum     = {1'b0, rnd_mant} + 25'(rnd_inc);
    if (rnd_sum[24]) begin
      rnd_frac = rnd_sum[23:1];
      rnd_exp  = ex_q + EW'(1);
    end else begin
      rnd_frac = rnd_sum[22:0];
      rnd_exp  = ex_q;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    a_d      = a_q;
    b_d      = b_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    ex_d     = ex_q;
    mx_d     = mx_q;
    my_d     = my_q;
    cnt_d    = cnt_q;
    pres_d   = pres_q;
    pflg_d   = pflg_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = operand_a;
          b_d     = {operand_b[31] ^ sub, operand_b[30:0]};
          flags_d = 5'd0;
          pflg_d  = 5'd0;
          busy_d  = 1'b1;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        state_d = S_DONE;
        if (a_nan || b_nan) begin
          pres_d = QNAN;
          pflg_d = FLG_INV;
        end else if (a_inf && b_inf && (a_q[31] != b_q[31])) begin
          pres_d = QNAN;
          pflg_d = FLG_INV;
        end else if (a_inf) begin
          pres_d = a_q;
        end else if (b_inf) begin
          pres_d = b_q;
        end else if (a_zero && b_zero) begin
          pres_d = {a_q[31] & b_q[31], 31'd0};
          pflg_d = FLG_ZERO;
        end else if (a_zero) begin
          pres_d = b_q;
        end else if (b_zero) begin
          pres_d = a_q;
        end else begin
          state_d = S_ALIGN;
          if (a_ge_b) begin
            sx_d  = a_q[31];
            sy_d  = b_q[31];
            ex_d  = {1'b0, ea};
            mx_d  = {2'b01, fa, 3'b000};
            my_d  = {1'b1, fb, 3'b000};
            cnt_d = ea - eb;
          end else begin
            sx_d  = b_q[31];
            sy_d  = a_q[31];
            ex_d  = {1'b0, eb};
            mx_d  = {2'b01, fb, 3'b000};
            my_d  = {1'b1, fa, 3'b000};
            cnt_d = eb - ea;
          end
        end
      end

      // One bit per cycle; far-apart operands collapse to a lone sticky bit
      S_ALIGN: begin
        if (32'(cnt_q) > ALIGN_LIMIT) begin
          my_d    = MW'(1);
          cnt_d   = 8'd0;
          state_d = S_ADD;
        end else if (cnt_q == 8'd0) begin
          state_d = S_ADD;
        end else begin
          my_d    = {1'b0, my_q[MW-1:2], my_q[1] | my_q[0]};
          cnt_d   = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = S_ADD;
          end
        end
      end

      S_ADD: begin
        state_d = S_NORM;
        if (sx_q == sy_q) begin
          mx_d = mag_sum;
        end else if (mag_diff == SW'(0)) begin
          pres_d  = 32'd0;
          pflg_d  = FLG_ZERO;
          state_d = S_DONE;
        end else begin
          mx_d = mag_diff;
        end
      end

      S_NORM: begin
        if (mx_q[SW-1]) begin
          mx_d    = {1'b0, mx_q[SW-1:2], mx_q[1] | mx_q[0]};
          ex_d    = ex_q + EW'(1);
          state_d = S_ROUND;
        end else if (mx_q[MW-1]) begin
          state_d = S_ROUND;
        end else if (ex_q == EW'(1)) begin
          // Left shift would leave the normal range: flush to signed zero
          pres_d  = {sx_q, 31'd0};
          pflg_d  = FLG_UNF | FLG_INX;
          state_d = S_DONE;
        end else begin
          mx_d = {mx_q[SW-2:0], 1'b0};
          ex_d = ex_q - EW'(1);
        end
      end

      S_ROUND: begin
        state_d = S_DONE;
        if (rnd_exp >= EW'(255)) begin
          pres_d = {sx_q, 8'hFF, 23'd0};
          pflg_d = FLG_OVF | FLG_INX;
        end else begin
          pres_d = {sx_q, rnd_exp[7:0], rnd_frac};
          pflg_d = rnd_inexact ? FLG_INX : 5'd0;
        end
      end

      S_DONE: begin
        result_d = pres_q;
        flags_d  = pflg_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
      flags_q  <= 5'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      ex_q     <= EW'(0);
      mx_q     <= SW'(0);
      my_q     <= MW'(0);
      cnt_q    <= 8'd0;
      pres_q   <= 32'd0;
      pflg_q   <= 5'd0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      ex_q     <= ex_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      cnt_q    <= cnt_d;
      pres_q   <= pres_d;
      pflg_q   <= pflg_d;
    end
  end

endmodule

// File: doc/fpu_addsub_core.md
Name: fpu_addsub_core

Overview:
- Multi-cycle IEEE-754 single-precision adder/subtractor.
- Sits directly downstream of the FPU bus-register front end. The front end presents operand_a, operand_b and the add/sub selection, pulses start, and on done captures result and flags into its result/status registers.
- Iterative shifters only; no barrel shifter. This keeps the area small for the CPLD/FPGA target.

Parameters:
- ALIGN_LIMIT, 26: exponent difference above which the smaller operand collapses to sticky in a single cycle.

Ports:
- clk  input  1  system clock
- arst  input  1  synchronous active-high reset
- start  input  1  one-cycle request; accepted only when busy=0
- sub  input  1  1 = a-b, 0 = a+b; sampled with start
- operand_a  input  32  IEEE-754 single; sampled with start
- operand_b  input  32  IEEE-754 single; sampled with start
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle pulse; result/flags valid the same cycle and held until next start
- result  output  32  packed IEEE-754 result
- flags  output  5  {invalid, overflow, underflow, inexact, zero}

Behaviour:
- Clock and reset:
  - Single clock clk.
  - arst is synchronous and active-high.
  - On reset: busy=0, done=0, result=0x00000000, flags=0, FSM=IDLE.
  - Reset mid-operation aborts with no done pulse.
- Start handshake:
  - start accepted in IDLE only; start while busy is ignored.
  - Inputs are latched on acceptance, so they may change afterwards.
  - If sub=1, b's sign is inverted at latch.
- FSM states: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
- UNPACK:
  - Exp=0 inputs are treated as zero (flush-to-zero; denormal inputs dropped).
  - Hidden bit is prepended: 24-bit mantissa, plus 3 extension bits G/R/S.
  - Special cases go UNPACK->DONE directly:
    - either NaN -> 0x7FC00000, invalid=1
    - +inf + -inf -> 0x7FC00000, invalid=1
    - one inf -> that inf
    - both zero -> sign = a_sign AND b_sign, zero=1
    - one zero -> other operand, unchanged, no rounding
  - Otherwise the operands are swapped so that |x| >= |y| (exponent, then mantissa).
- ALIGN:
  - d = ex - ey.
  - If d > ALIGN_LIMIT: y collapses to sticky=1 in one cycle.
  - Otherwise y shifts right one bit per cycle for d cycles; bits shifted past S are ORed into S.
- ADD:
  - Same signs: 28-bit mantissa sum (carry bit included).
  - Different signs: difference x - y, never negative. Result sign = x sign.
  - Exact zero difference -> +0, zero=1, go to DONE.
- NORM:
  - Carry set: shift right 1 (LSB OR into S), exp+1, one cycle.
  - Else: shift left one bit per cycle until bit23=1. If exp would reach 0, the result is flushed to signed zero with underflow=1 and inexact=1.
- ROUND:
  - Truncate G/R/S (see optional feature); inexact = G|R|S.
  - Mantissa overflow after rounding -> shift right, exp+1.
  - exp >= 255 -> signed inf, overflow=1, inexact=1.
- DONE:
  - result and flags registered; done=1 for exactly one cycle; busy drops in the same cycle.
- Latency:
  - Special-case path: 3 cycles start->done.
  - General path: 6 + align shifts + normalize shifts.
  - Worst case is at most 60 cycles.
- flags are cleared at each accepted start.

Optional Feature:
- FPU_ROUND_NEAREST_EN:
  - Defined: ROUND uses round-to-nearest-even: increment if G & (R|S|LSB).
  - Undefined: round-toward-zero (truncate).
- inexact is computed identically in both builds.

Test Plan:
- a=0x3F800000, b=0x40000000, sub=0 -> result 0x40400000, flags=0, done pulses once, busy low afterwards.
- a=0x3F800000, b=0x3F800000, sub=1 -> result 0x00000000, zero=1.
- a=0x7F800000, b=0xFF800000, sub=0 -> result 0x7FC00000, invalid=1, done on the 3rd cycle after start.
- a=0x7F7FFFFF, b=0x7F7FFFFF, sub=0 -> result 0x7F800000, overflow=1, inexact=1.
- a=0x3F800000, b=0x33C00000, sub=0:
  - with FPU_ROUND_NEAREST_EN -> result 0x3F800001, inexact=1
  - without FPU_ROUND_NEAREST_EN -> result 0x3F800000, inexact=1
- a=0x40000000, b=0x3F800000, start asserted, arst pulsed on cycle 4 -> busy=0, no done pulse, result=0, flags=0. A following start with a=0x40000000, b=0x3F800000, sub=1 -> result 0x3F800000.
